instr_sequencer: RTL

Autonomous instruction issuer for the TPU top level. It holds a small program of 16-bit instructions with per-entry hold counts, loaded through a host write port. On `start` it drives the `instruction` bus cycle by cycle, replacing hand-timed stimulus. It sits directly upstream of the top-level instruction input and reports `busy`/`done` to the host.

---
 rtl/tpu_isa_pkg.sv | 24 ++
 rtl/instr_sequencer_if.sv | 31 +++
 rtl/instr_prog_mem.sv | 45 ++++
 rtl/instr_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/tpu_isa_pkg.sv
// Shared TPU instruction-set definitions: the opcode encoding and where the
// opcode sits inside an instruction word.
package tpu_isa_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 3;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP         = 3'b000,
    OPC_LOAD_ADDR   = 3'b001,
    OPC_LOAD_WEIGHT = 3'b010,
    OPC_VALID       = 3'b100,
    OPC_HALT        = 3'b111
  } opcode_e;

  localparam logic [INSTR_W-1:0] HALT_INSTR = {OPC_HALT, {(INSTR_W-OPC_W){1'b0}}};

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Host-facing bus of the instruction sequencer: the program write port,
// start/abort control, and the issued instruction with its status.
interface instr_sequencer_if #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = tpu_isa_pkg::INSTR_W,
  parameter int HOLD_W  = 4
);
  localparam int AW = $clog2(DEPTH);

  logic               prog_we;
  logic [AW-1:0]      prog_addr;
  logic [INSTR_W-1:0] prog_instr;
  logic [HOLD_W-1:0]  prog_hold;
  logic               start;
  logic               abort;
  logic [INSTR_W-1:0] instruction;
  logic [AW-1:0]      issue_pc;
  logic               busy;
  logic               done;

  modport master (
    output prog_we, prog_addr, prog_instr, prog_hold, start, abort,
    input  instruction, issue_pc, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_instr, prog_hold, start, abort,
    output instruction, issue_pc, busy, done
  );

endinterface

// File: rtl/instr_prog_mem.sv
// Program store: DEPTH entries of {instruction, hold}, one write port and one
// combinational read port. Reset fills every entry with HALT and zero hold.
module instr_prog_mem #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = tpu_isa_pkg::INSTR_W,
  parameter int HOLD_W  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata_instr,
  input  logic [HOLD_W-1:0]  i_wdata_hold,
  input  logic [AW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata_instr,
  output logic [HOLD_W-1:0]  o_rdata_hold
);
  import tpu_isa_pkg::*;

  localparam logic [INSTR_W-1:0] RESET_INSTR = {OPC_HALT, {(INSTR_W-OPC_W){1'b0}}};

  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [HOLD_W-1:0]  r_hold  [DEPTH];

  // NOTE: this array is deliberately reset (flops, not RAM) so a reset leaves
  // a program that halts at entry 0; a RAM macro could not be cleared this way.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= RESET_INSTR;
        r_hold[i]  <= '0;
      end
    end else if (i_we) begin
      // NOTE: sequential state is updated with <= so every flop samples the
      // pre-edge values; blocking = here would create order-dependent races.
      r_instr[i_waddr] <= i_wdata_instr;
      r_hold[i_waddr]  <= i_wdata_hold;
    end
  end

  assign o_rdata_instr = r_instr[i_raddr];
  assign o_rdata_hold  = r_hold[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Autonomous instruction issuer: plays the stored program onto a registered
// instruction bus, holding each entry for hold+1 cycles until HALT or the end.
module instr_sequencer #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = tpu_isa_pkg::INSTR_W,
  parameter int HOLD_W  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  instr_sequencer_if.slave    bus
);
  import tpu_isa_pkg::*;

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e             r_state, w_state_nxt;
  logic [AW-1:0]      r_pc, w_pc_nxt;
  logic [HOLD_W-1:0]  r_cnt, w_cnt_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;

  logic               w_we;
  logic [AW-1:0]      w_rd_addr;
  logic [INSTR_W-1:0] w_rd_instr;
  logic [HOLD_W-1:0]  w_rd_hold;
  logic               w_rd_halt;
  logic               w_last_pc;

  assign w_we      = bus.prog_we && (r_state == IDLE);
  // The single read port looks at entry 0 while idle and at the next entry while issuing.
  assign w_rd_addr = (r_state == ISSUE) ? r_pc + AW'(1) : '0;
  assign w_rd_halt = (w_rd_instr[OPC_MSB:OPC_LSB] == OPC_HALT);
  assign w_last_pc = (r_pc == AW'(DEPTH - 1));

  instr_prog_mem #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W),
    .HOLD_W  (HOLD_W)
  ) u_prog_mem (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_we          (w_we),
    .i_waddr       (bus.prog_addr),
    .i_wdata_instr (bus.prog_instr),
    .i_wdata_hold  (bus.prog_hold),
    .i_raddr       (w_rd_addr),
    .o_rdata_instr (w_rd_instr),
    .o_rdata_hold  (w_rd_hold)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_instr <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_instr <= w_instr_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_instr_nxt = r_instr;

    if (bus.abort) begin
      w_state_nxt = IDLE;
      w_pc_nxt    = '0;
      w_cnt_nxt   = '0;
      w_instr_nxt = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_instr_nxt = '0;
          // A program write in the same cycle wins over start.
          if (bus.start && !bus.prog_we) begin
            w_pc_nxt = '0;
            if (w_rd_halt) begin
              w_state_nxt = DONE;
            end else begin
              w_state_nxt = ISSUE;
              w_instr_nxt = w_rd_instr;
              w_cnt_nxt   = w_rd_hold;
            end
          end
        end
        ISSUE: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - HOLD_W'(1);
          end else if (w_last_pc || w_rd_halt) begin
            w_state_nxt = DONE;
            w_pc_nxt    = '0;
            w_instr_nxt = '0;
          end else begin
            w_pc_nxt    = r_pc + AW'(1);
            w_instr_nxt = w_rd_instr;
            w_cnt_nxt   = w_rd_hold;
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
          w_instr_nxt = '0;
        end
        default: begin
          w_state_nxt = IDLE;
          w_pc_nxt    = '0;
          w_cnt_nxt   = '0;
          w_instr_nxt = '0;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == ISSUE);
    w_done_nxt = (w_state_nxt == DONE);
  end

  assign bus.instruction = r_instr;
  assign bus.issue_pc    = r_pc;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule
